// File: rtl/mips_write_checker_if.sv
// rtl/mips_write_checker_if.sv - tapped dmem write port shared by dmem and the checker
interface mips_write_checker_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              memwrite;
   logic [ADDR_W-1:0] dataadr;
   logic [DATA_W-1:0] writedata;

   modport master (output memwrite, dataadr, writedata);
   modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mips_write_checker.sv
// rtl/mips_write_checker.sv - compares dmem writes against an ordered expected-write table
module mips_write_checker #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16,
   parameter int STRICT  = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [IDX_W-1:0]    cfg_idx,
   input  logic [ADDR_W-1:0]   cfg_addr,
   input  logic [DATA_W-1:0]   cfg_data,
   input  logic [IDX_W:0]      cfg_num,
   input  logic                start,
   mips_write_checker_if.slave bus,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [1:0]          fail_code,
   output logic [IDX_W:0]      match_cnt,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_data
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   localparam logic [IDX_W:0]   DEPTH_V      = (IDX_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam bit               STRICT_B     = (STRICT != 0);

   state_t            state;
   logic [IDX_W:0]    num_lat;
   logic [ADDR_W-1:0] exp_addr [DEPTH];
   logic [DATA_W-1:0] exp_data [DEPTH];

   logic [IDX_W-1:0] cur_idx;
   logic [IDX_W:0]   match_next;
   logic [IDX_W:0]   num_clamped;
   logic [CNT_W-1:0] cnt_inc;
   logic             addr_hit;
   logic             data_hit;
   logic             last_cycle;

   // The expected table is deliberately left out of reset so a board can reload it once and rerun.
   always_ff @(posedge clk) begin
      if (cfg_we && (int'(cfg_idx) < DEPTH)) begin
         exp_addr[cfg_idx] <= cfg_addr;
         exp_data[cfg_idx] <= cfg_data;
      end
   end

   always_comb begin
      cur_idx     = match_cnt[IDX_W-1:0];
      match_next  = match_cnt + 1'b1;
      num_clamped = ((cfg_num == '0) || (cfg_num > DEPTH_V)) ? DEPTH_V : cfg_num;
      cnt_inc     = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
      addr_hit    = (bus.dataadr == exp_addr[cur_idx]);
      data_hit    = (bus.writedata == exp_data[cur_idx]);
      last_cycle  = (cycle_cnt == TIMEOUT_LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_code <= 2'd0;
         match_cnt <= '0;
         cycle_cnt <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         num_lat   <= '0;
      end else if (start) begin
         state     <= S_RUN;
         busy      <= 1'b1;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_code <= 2'd0;
         match_cnt <= '0;
         cycle_cnt <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         num_lat   <= num_clamped;
      end else if (state == S_RUN) begin
         cycle_cnt <= cnt_inc;
         // A completing match beats the timeout in the same cycle.
         if (bus.memwrite && addr_hit && data_hit) begin
            match_cnt <= match_next;
            if (match_next == num_lat) begin
               state <= S_PASS;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= 1'b1;
            end else if (last_cycle) begin
               state     <= S_FAIL;
               busy      <= 1'b0;
               done      <= 1'b1;
               fail_code <= 2'd3;
            end
         end else if (bus.memwrite && (addr_hit || STRICT_B)) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= addr_hit ? 2'd1 : 2'd2;
            fail_addr <= bus.dataadr;
            fail_data <= bus.writedata;
         end else if (last_cycle) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= 2'd3;
            fail_addr <= '0;
            fail_data <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mips_write_checker.sv
// tb/tb_mips_write_checker.sv - directed-vector bench for mips_write_checker, lax and strict instances
module tb_mips_write_checker;
   localparam int ADDR_W = 32, DATA_W = 32, DEPTH = 4, IDX_W = 2, TIMEOUT = 16, CNT_W = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cfg_we = 1'b0;
   logic [IDX_W-1:0]  cfg_idx = '0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [DATA_W-1:0] cfg_data = '0;
   logic [IDX_W:0]    cfg_num = '0;
   logic start = 1'b0;

   logic busy_l, done_l, pass_l, busy_s, done_s, pass_s;
   logic [1:0] fc_l, fc_s;
   logic [IDX_W:0] mc_l, mc_s;
   logic [CNT_W-1:0] cc_l, cc_s;
   logic [ADDR_W-1:0] fa_l, fa_s;
   logic [DATA_W-1:0] fd_l, fd_s;

   int n_vec = 0;
   int n_bad = 0;

   mips_write_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   always #5 clk = ~clk;

   mips_write_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .STRICT(0)) dut_lax (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_num(cfg_num), .start(start), .bus(bus.slave),
      .busy(busy_l), .done(done_l), .pass(pass_l), .fail_code(fc_l), .match_cnt(mc_l),
      .cycle_cnt(cc_l), .fail_addr(fa_l), .fail_data(fd_l));

   mips_write_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .STRICT(1)) dut_strict (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_num(cfg_num), .start(start), .bus(bus.slave),
      .busy(busy_s), .done(done_s), .pass(pass_s), .fail_code(fc_s), .match_cnt(mc_s),
      .cycle_cnt(cc_s), .fail_addr(fa_s), .fail_data(fd_s));

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic load(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic arm(input logic [IDX_W:0] num);
      cfg_num = num; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
      tick();
      bus.memwrite = 1'b0;
   endtask

   initial begin
      bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
      #12;
      check_val("rst_busy", busy_l, 0);
      check_val("rst_done", done_l, 0);
      check_val("rst_cnts", {mc_l, cc_l, fc_l}, 0);
      check_val("rst_fail_ad", {fa_l, fd_l}, 0);
      @(negedge clk); reset = 1'b1;
      tick();

      // Single entry, matching write during RUN cycle 5
      load(0, 84, 7);
      arm(1);
      check_val("t1_busy_lat", busy_l, 1);
      idle(5);
      wr(84, 7);
      check_val("t1_pass", {pass_l, done_l, busy_l}, 3'b110);
      check_val("t1_match", mc_l, 1);
      check_val("t1_cycles", cc_l, 6);
      check_val("t1_strict_pass", pass_s, 1);

      // Stray write to another address: ignored when lax, fatal when strict
      load(0, 80, 1);
      load(1, 84, 7);
      arm(2);
      wr(60, 3);
      check_val("t2_strict_code", fc_s, 2);
      wr(80, 1);
      wr(84, 7);
      check_val("t2_lax_pass", pass_l, 1);
      check_val("t2_lax_match", mc_l, 2);
      check_val("t2_strict_hold", {done_s, pass_s, fc_s}, 4'b1010);
      check_val("t2_strict_addr", fa_s, 60);
      check_val("t2_strict_data", fd_s, 3);
      check_val("t2_strict_match", mc_s, 0);

      // Data mismatch
      load(0, 84, 7);
      arm(1);
      wr(84, 5);
      check_val("t3_code", {done_l, pass_l, fc_l}, 4'b1001);
      check_val("t3_addr_data", {fa_l, fd_l}, {32'd84, 32'd5});
      check_val("t3_match", mc_l, 0);

      // Timeout exactly 16 cycles after start
      arm(1);
      idle(15);
      check_val("t4_not_yet", {busy_l, done_l}, 2'b10);
      idle(1);
      check_val("t4_timeout", {done_l, pass_l, fc_l}, 4'b1011);
      check_val("t4_fail_ad", {fa_l, fd_l}, 0);
      check_val("t4_cycles", cc_l, 16);
      check_val("t4_strict", fc_s, 3);

      // Matching write on the timeout cycle wins
      arm(1);
      idle(15);
      wr(84, 7);
      check_val("t4b_pass", {pass_l, fc_l}, 3'b100);
      check_val("t4b_strict", pass_s, 1);

      // Async reset mid-RUN, table survives reset
      load(0, 80, 1);
      load(1, 84, 7);
      arm(2);
      wr(80, 1);
      check_val("t5_one_match", mc_l, 1);
      reset = 1'b0;
      #2;
      check_val("t5_async_clr", {busy_l, done_l, pass_l, fc_l}, 0);
      check_val("t5_async_cnts", {mc_l, cc_l}, 0);
      tick();
      reset = 1'b1;
      idle(2);
      check_val("t5_stay_idle", {busy_l, cc_l}, 0);
      arm(2);
      wr(80, 1);
      wr(84, 7);
      check_val("t5_pass", {pass_l, mc_l}, {1'b1, 3'd2});

      // cfg_num=0 clamps to DEPTH; start in PASS re-arms
      load(0, 32'h100, 32'hA0);
      load(1, 32'h104, 32'hA1);
      load(2, 32'h108, 32'hA2);
      load(3, 32'h10C, 32'hA3);
      arm(0);
      wr(32'h100, 32'hA0);
      wr(32'h104, 32'hA1);
      wr(32'h108, 32'hA2);
      check_val("t6_three_busy", {busy_l, done_l, mc_l}, {2'b10, 3'd3});
      wr(32'h10C, 32'hA3);
      check_val("t6_pass", {pass_l, mc_l}, {1'b1, 3'd4});
      arm(7);
      check_val("t6_rearm", {busy_l, pass_l, done_l, mc_l, cc_l}, {3'b100, 3'd0, 16'd0});

      // start with a simultaneous write restarts and ignores the write; cfg_num=7 clamps to 4
      wr(32'h100, 32'hA0);
      check_val("t7_first", mc_l, 1);
      start = 1'b1;
      wr(32'h104, 32'hA1);
      start = 1'b0;
      check_val("t7_restart", {busy_l, mc_l, cc_l}, {1'b1, 3'd0, 16'd0});
      wr(32'h100, 32'hA0);
      wr(32'h104, 32'hA1);
      wr(32'h108, 32'hA2);
      check_val("t7_clamp7", {busy_l, mc_l}, {1'b1, 3'd3});
      wr(32'h10C, 32'hA3);
      check_val("t7_pass", {pass_l, pass_s, mc_s}, {2'b11, 3'd4});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
